// File: rtl/tdc_ctrl_pkg.sv
// Shared definitions for the TDC shot controller.
// Holds the one-hot state encoding, the default timing constants and a
// small width helper used for counter sizing.
package tdc_ctrl_pkg;

    localparam int unsigned START_W_DEF    = 4;
    localparam int unsigned WIN_MARGIN_DEF = 4;
    localparam int unsigned DRAIN_TO_DEF   = 1024;

    // One-hot controller state, 7 bits
    typedef enum logic [6:0] {
        S_IDLE   = 7'b000_0001,
        S_ARM    = 7'b000_0010,
        S_START  = 7'b000_0100,
        S_WINDOW = 7'b000_1000,
        S_DRAIN  = 7'b001_0000,
        S_GAP    = 7'b010_0000,
        S_DONE   = 7'b100_0000
    } state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/tdc_sync2.sv
// Two-flop synchronizer, parameterized width, async active-low reset.
// Ports: clk5, rst_n, d (async input), q (synchronized, 2-cycle latency).
module tdc_sync2 #(
    parameter int unsigned W = 1
) (
    input  logic         clk5,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk5 or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tdc_shot_ctrl.sv
// Shot scheduler for the TDC core (clk5 domain).
// On frame_req fires cfg_shots start pulses, holds tdc_range per frame,
// waits out the measurement window, then the readout drain (or skips it when
// no hits were captured), then the inter-shot gap.
// Ports:
//   clk5, rst_n                  clock, async active-low reset
//   cfg_en/range/shots/gap       configuration, latched on frame accept
//   frame_req                    single-cycle frame request
//   tdc_onum, tdc_olast          TDC readout status (synchronized here)
//   tdc_start                    start pulse, gated by cfg_en
//   tdc_range                    range presented to TDC
//   busy, shot_idx               frame status
//   frame_done, abort            one-cycle event pulses
//   timeout_err                  sticky drain timeout flag
//   empty_shots, hit_total       per-frame statistics
// Build option: define TDC_SHOT_STATS_EN to implement the statistics
// counters; otherwise empty_shots and hit_total are tied to zero.
module tdc_shot_ctrl
    import tdc_ctrl_pkg::*;
#(
    parameter int unsigned RANGE_W    = 15,
    parameter int unsigned SHOT_W     = 8,
    parameter int unsigned GAP_W      = 8,
    parameter int unsigned START_W    = START_W_DEF,
    parameter int unsigned WIN_MARGIN = WIN_MARGIN_DEF,
    parameter int unsigned DRAIN_TO   = DRAIN_TO_DEF
) (
    input  logic                clk5,
    input  logic                rst_n,
    input  logic                cfg_en,
    input  logic [RANGE_W-1:0]  cfg_range,
    input  logic [SHOT_W-1:0]   cfg_shots,
    input  logic [GAP_W-1:0]    cfg_gap,
    input  logic                frame_req,
    input  logic [1:0]          tdc_onum,
    input  logic                tdc_olast,
    output logic                tdc_start,
    output logic [RANGE_W-1:0]  tdc_range,
    output logic                busy,
    output logic [SHOT_W-1:0]   shot_idx,
    output logic                frame_done,
    output logic                abort,
    output logic                timeout_err,
    output logic [SHOT_W-1:0]   empty_shots,
    output logic [SHOT_W+1:0]   hit_total
);

    // One shared phase counter sized for the longest of window, gap, drain, start
    localparam int unsigned CNT_W = max_u(max_u(RANGE_W + 1, GAP_W + 1),
                                          max_u($clog2(DRAIN_TO) + 1, $clog2(START_W) + 1));

    state_e               state, state_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [RANGE_W-1:0]   range_q;
    logic [SHOT_W-1:0]    shots_q;
    logic [GAP_W-1:0]     gap_q;
    logic [1:0]           onum_s;
    logic                 olast_s, olast_d, olast_rise;
    logic                 start_q;
    logic                 last_shot;
    logic [CNT_W-1:0]     win_last;
    logic                 accept, load_range, drain_tmo, shot_inc, do_abort;

    tdc_sync2 #(.W(2)) u_sync_onum (
        .clk5  (clk5),
        .rst_n (rst_n),
        .d     (tdc_onum),
        .q     (onum_s)
    );

    tdc_sync2 #(.W(1)) u_sync_olast (
        .clk5  (clk5),
        .rst_n (rst_n),
        .d     (tdc_olast),
        .q     (olast_s)
    );

    assign olast_rise = olast_s & ~olast_d;
    assign last_shot  = (shot_idx == shots_q - SHOT_W'(1));
    assign win_last   = CNT_W'(range_q) + CNT_W'(WIN_MARGIN - 1);

    // Start pulse drops in the same cycle cfg_en falls
    assign tdc_start  = start_q & cfg_en;

    // State and phase counter registers
    always_ff @(posedge clk5 or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Next-state and control strobes
    always_comb begin
        state_d    = state;
        accept     = 1'b0;
        load_range = 1'b0;
        drain_tmo  = 1'b0;
        shot_inc   = 1'b0;
        do_abort   = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (frame_req && cfg_en) begin
                    accept  = 1'b1;
                    state_d = S_ARM;
                end
            end
            S_ARM: begin
                load_range = 1'b1;
                state_d    = S_START;
            end
            S_START: begin
                if (cnt == CNT_W'(START_W - 1)) state_d = S_WINDOW;
            end
            S_WINDOW: begin
                if (cnt == win_last) state_d = (onum_s == 2'd0) ? S_GAP : S_DRAIN;
            end
            S_DRAIN: begin
                if (olast_rise) begin
                    state_d = S_GAP;
                end else if (cnt == CNT_W'(DRAIN_TO - 1)) begin
                    drain_tmo = 1'b1;
                    state_d   = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt == CNT_W'(gap_q)) begin
                    if (last_shot) begin
                        state_d = S_DONE;
                    end else begin
                        shot_inc = 1'b1;
                        state_d  = S_ARM;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Disable overrides every in-frame action
        if (state != S_IDLE && !cfg_en) begin
            state_d    = S_IDLE;
            do_abort   = 1'b1;
            load_range = 1'b0;
            drain_tmo  = 1'b0;
            shot_inc   = 1'b0;
        end

        // Counter restarts on every state change
        cnt_d = (state_d != state || state == S_IDLE) ? '0 : cnt + CNT_W'(1);
    end

    // Registered outputs and shadow configuration
    always_ff @(posedge clk5 or negedge rst_n) begin
        if (!rst_n) begin
            start_q     <= 1'b0;
            tdc_range   <= '1;
            busy        <= 1'b0;
            shot_idx    <= '0;
            frame_done  <= 1'b0;
            abort       <= 1'b0;
            timeout_err <= 1'b0;
            range_q     <= '0;
            shots_q     <= SHOT_W'(1);
            gap_q       <= '0;
            olast_d     <= 1'b0;
        end else begin
            start_q    <= (state_d == S_START);
            busy       <= (state_d != S_IDLE);
            frame_done <= (state_d == S_DONE);
            abort      <= do_abort;
            olast_d    <= olast_s;
            if (accept) begin
                range_q     <= cfg_range;
                shots_q     <= (cfg_shots == '0) ? SHOT_W'(1) : cfg_shots;
                gap_q       <= cfg_gap;
                shot_idx    <= '0;
                timeout_err <= 1'b0;
            end
            if (load_range) tdc_range   <= range_q;
            if (drain_tmo)  timeout_err <= 1'b1;
            if (shot_inc)   shot_idx    <= shot_idx + SHOT_W'(1);
        end
    end

`ifdef TDC_SHOT_STATS_EN
    // Per-frame statistics, saturating, sampled at window expiry
    logic [SHOT_W-1:0] empty_q;
    logic [SHOT_W+1:0] hit_q;
    logic [SHOT_W+2:0] hit_sum;
    logic              win_exp;

    assign win_exp = (state == S_WINDOW) && (cnt == win_last) && cfg_en;
    assign hit_sum = {1'b0, hit_q} + (SHOT_W + 3)'(onum_s);

    always_ff @(posedge clk5 or negedge rst_n) begin
        if (!rst_n) begin
            empty_q <= '0;
            hit_q   <= '0;
        end else if (accept) begin
            empty_q <= '0;
            hit_q   <= '0;
        end else if (win_exp) begin
            if (onum_s == 2'd0) begin
                if (empty_q != '1) empty_q <= empty_q + SHOT_W'(1);
            end else begin
                hit_q <= hit_sum[SHOT_W+2] ? '1 : hit_sum[SHOT_W+1:0];
            end
        end
    end

    assign empty_shots = empty_q;
    assign hit_total   = hit_q;
`else
    assign empty_shots = '0;
    assign hit_total   = '0;
`endif

endmodule
